ccd_pixel_sequencer: RTL and testbench
======================================

# ccd_pixel_sequencer

Parametrised, single-clock successor to the CCD analog signal generator. Synchronises the CCD line clock (phi_p) and pixel clock (phi_l2) into the system clock domain, counts pixels per line, and generates the ADC frame window, a delayed ADC start strobe per pixel, a programmable pixel flag and an end-of-line pulse. Sits between the CCD clock driver and the ADC capture block in the signal-generator subsystem.

## Interface
Parameters:
- PIX_W, 12: width of pixel counter, line length and flag index.
- ADC_DLY, 4: i_clk cycles from registered phi_l2 edge to o_adc_start; legal range 1..15.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  sequencer enable (synchronous to i_clk).
- i_phi_p  in  1  line-start clock, asynchronous.
- i_phi_l2  in  1  pixel clock, asynchronous.
- i_line_len  in  PIX_W  pixels per line; sampled at line start.
- i_flag_idx  in  PIX_W  pixel number (1-based) that raises o_pixel_flag; sampled at line start.
- o_ADC_frame  out  1  high while a line is active.
- o_adc_start  out  1  one-cycle ADC conversion strobe.
- o_pixel_flag  out  1  one-cycle pulse at the flagged pixel.
- o_line_done  out  1  one-cycle pulse when the line completes.
- o_pix_idx  out  PIX_W  pixels counted in current line.
- o_overrun  out  1  sticky overrun flag (only with macro, see Configuration; else tied 0).

## Operation
- Each async input passes through a 2-FF synchroniser plus edge-detect flop; produces one-cycle rise pulses p_rise, l2_rise.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE: p_rise with i_enable=1 -> ACTIVE; latch i_line_len, i_flag_idx; o_pix_idx<=0. If latched line_len==0 -> DONE directly, o_line_done pulses, o_ADC_frame stays 0.
  - ACTIVE: o_ADC_frame=1. Each l2_rise: o_pix_idx+1; arm ADC delay counter; if new count == flag_idx, o_pixel_flag pulses same cycle. New count == line_len -> DONE, o_line_done pulses same cycle, o_ADC_frame drops next cycle.
  - DONE: l2_rise ignored (counter saturates at line_len); p_rise with i_enable=1 -> ACTIVE (new line); i_enable=0 -> IDLE.
- p_rise in ACTIVE: restart line (counter 0, re-latch config); o_line_done not pulsed; pending ADC strobe cancelled.
- p_rise and l2_rise in same cycle: p_rise wins, l2_rise discarded.
- i_enable=0 in ACTIVE: -> IDLE next cycle, o_ADC_frame 0, pending strobe cancelled, o_pix_idx holds.
- Pending strobe still fires after DONE entry (last pixel gets its conversion).
- flag_idx==0 or > line_len: o_pixel_flag never pulses.
- Reset: state IDLE, all outputs 0, o_pix_idx 0, synchronisers cleared.

## Timing
- Input rise first sampled at edge N -> p_rise/l2_rise high in cycle N+2.
- o_adc_start high exactly ADC_DLY cycles after the l2_rise cycle, for one cycle.
- o_pixel_flag, o_line_done, o_pix_idx update: registered, visible the cycle after l2_rise.
- o_ADC_frame rises the cycle after p_rise.
- Minimum phi_l2 period: ADC_DLY+1 i_clk cycles; a new l2_rise while a strobe is pending restarts the delay (earlier strobe lost).

## Configuration
- CCD_SEQ_OVERRUN_DET_EN defined: l2_rise arriving while ADC delay pending sets o_overrun; stays set until reset or next line-start p_rise. Delay still restarts.
- Undefined: no detection logic; o_overrun tied 0.

## Structure
- Package ccd_seq_pkg: FSM state encoding (IDLE/ACTIVE/DONE), ADC delay counter width constant (4), default PIX_W.
- Sub-module ccd_edge_sync: 2-FF synchroniser + rising-edge detector, async active-low reset; instantiated twice.

## Test plan
- Reset mid-line (pix_idx=5) -> all outputs 0, state IDLE; next p_rise starts fresh line from 0.
- line_len=8, flag_idx=5, ADC_DLY=4, 8 phi_l2 pulses (period 10 clk) -> 8 o_adc_start each 4 cycles after l2_rise, one o_pixel_flag at pix_idx=5, o_line_done with pix_idx=8, frame low after.
- 10 phi_l2 pulses with line_len=8 -> pix_idx saturates at 8, only 8 ADC strobes, single o_line_done.
- phi_p rising same cycle as phi_l2 during ACTIVE at pix_idx=3 -> pix_idx 0, no strobe from that edge, no o_line_done.
- phi_l2 period 3 clk with ADC_DLY=4, macro defined -> o_overrun set, cleared by next p_rise; macro undefined -> o_overrun stays 0.
- line_len=0 -> o_line_done pulses after p_rise, o_ADC_frame never rises; i_enable=0 mid-line -> IDLE, no further strobes.

Source files
------------

// File: rtl/ccd_seq_pkg.sv
// Shared types and constants for the CCD pixel sequencer.
package ccd_seq_pkg;

   localparam int DEFAULT_PIX_W = 12;
   localparam int ADC_CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/ccd_edge_sync.sv
// Two-flop synchroniser followed by an edge-detect flop; emits a registered one-cycle rise pulse.
module ccd_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
         rise <= sync & ~prev;
      end
   end

endmodule

// File: rtl/ccd_pixel_sequencer.sv
// CCD pixel sequencer: counts pixels per line and times the ADC frame, strobe, flag and end-of-line.
// Sticky overrun detection is built only when CCD_SEQ_OVERRUN_DET_EN is defined.
module ccd_pixel_sequencer
   import ccd_seq_pkg::*;
#(
   parameter int PIX_W   = DEFAULT_PIX_W,
   parameter int ADC_DLY = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_phi_p,
   input  logic             i_phi_l2,
   input  logic [PIX_W-1:0] i_line_len,
   input  logic [PIX_W-1:0] i_flag_idx,
   output logic             o_ADC_frame,
   output logic             o_adc_start,
   output logic             o_pixel_flag,
   output logic             o_line_done,
   output logic [PIX_W-1:0] o_pix_idx,
   output logic             o_overrun
);

   // The counter is loaded with ADC_DLY-1 so the registered strobe lands exactly ADC_DLY cycles out.
   localparam logic [ADC_CNT_W-1:0] DLY_LOAD   = ADC_CNT_W'(ADC_DLY - 1);
   localparam logic                 STROBE_NOW = (ADC_DLY == 1);

   seq_state_t           state, state_next;
   logic [PIX_W-1:0]     pix_idx, pix_next, pix_inc;
   logic [PIX_W-1:0]     line_len, len_next;
   logic [PIX_W-1:0]     flag_idx, flag_idx_next;
   logic [ADC_CNT_W-1:0] dly_cnt, dly_next;
   logic                 adc_start, adc_next;
   logic                 pixel_flag, flag_next;
   logic                 line_done, done_next;
   logic                 p_rise, l2_rise;
   logic                 line_start, arm, cancel;

   ccd_edge_sync u_phi_p_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_phi_p),
      .rise  (p_rise)
   );

   ccd_edge_sync u_phi_l2_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_phi_l2),
      .rise  (l2_rise)
   );

   assign pix_inc = pix_idx + 1'b1;

   always_comb begin
      state_next    = state;
      pix_next      = pix_idx;
      len_next      = line_len;
      flag_idx_next = flag_idx;
      dly_next      = dly_cnt;
      flag_next     = 1'b0;
      done_next     = 1'b0;
      line_start    = 1'b0;
      arm           = 1'b0;
      cancel        = 1'b0;

      case (state)
         IDLE: begin
            if (p_rise && i_enable) line_start = 1'b1;
         end
         ACTIVE: begin
            if (!i_enable) begin
               state_next = IDLE;
               cancel     = 1'b1;
            end else if (p_rise) begin
               line_start = 1'b1;
               cancel     = 1'b1;
            end else if (l2_rise) begin
               arm      = 1'b1;
               pix_next = pix_inc;
               if (pix_inc == flag_idx) flag_next = 1'b1;
               if (pix_inc == line_len) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end
         end
         DONE: begin
            if (!i_enable)   state_next = IDLE;
            else if (p_rise) line_start = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      // A zero-length line completes on the spot and never opens the frame.
      if (line_start) begin
         len_next      = i_line_len;
         flag_idx_next = i_flag_idx;
         pix_next      = '0;
         if (i_line_len == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
         end else begin
            state_next = ACTIVE;
         end
      end

      if (arm)                 dly_next = DLY_LOAD;
      else if (cancel)         dly_next = '0;
      else if (dly_cnt != '0)  dly_next = dly_cnt - 1'b1;

      adc_next = arm ? STROBE_NOW : (!cancel && (dly_cnt == ADC_CNT_W'(1)));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         pix_idx    <= '0;
         line_len   <= '0;
         flag_idx   <= '0;
         dly_cnt    <= '0;
         adc_start  <= 1'b0;
         pixel_flag <= 1'b0;
         line_done  <= 1'b0;
      end else begin
         state      <= state_next;
         pix_idx    <= pix_next;
         line_len   <= len_next;
         flag_idx   <= flag_idx_next;
         dly_cnt    <= dly_next;
         adc_start  <= adc_next;
         pixel_flag <= flag_next;
         line_done  <= done_next;
      end
   end

`ifdef CCD_SEQ_OVERRUN_DET_EN
   logic overrun;

   // A pixel edge that restarts a still-pending conversion delay marks the line as overrun.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                     overrun <= 1'b0;
      else if (line_start)              overrun <= 1'b0;
      else if (arm && (dly_cnt != '0))  overrun <= 1'b1;
   end

   assign o_overrun = overrun;
`else
   assign o_overrun = 1'b0;
`endif

   assign o_ADC_frame  = (state == ACTIVE);
   assign o_adc_start  = adc_start;
   assign o_pixel_flag = pixel_flag;
   assign o_line_done  = line_done;
   assign o_pix_idx    = pix_idx;

endmodule

// File: tb/tb_ccd_pixel_sequencer.sv
// Self-checking bench for ccd_pixel_sequencer: table-driven lines, randomized lines against a timing model, corner sequences.
module tb_ccd_pixel_sequencer;

   localparam int PIX_W   = 12;
   localparam int ADC_DLY = 4;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic             phi_p;
   logic             phi_l2;
   logic [PIX_W-1:0] line_len;
   logic [PIX_W-1:0] flag_idx;
   logic             frame;
   logic             adc_start;
   logic             pixel_flag;
   logic             line_done;
   logic [PIX_W-1:0] pix_idx;
   logic             overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int frame_rises = 0;
   bit frame_prev  = 0;
   bit prev_active = 0;

   int strobe_q[$];
   int flag_q[$];
   int flag_pix_q[$];
   int done_q[$];
   int done_pix_q[$];

   typedef struct {
      int len;
      int flag;
      int npulses;
      int period;
      int exp_strobes;
      int exp_flags;
      int exp_dones;
      int exp_pix;
      int exp_frame;
   } vec_t;

   vec_t vecs[7];

   ccd_pixel_sequencer #(
      .PIX_W   (PIX_W),
      .ADC_DLY (ADC_DLY)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable),
      .i_phi_p      (phi_p),
      .i_phi_l2     (phi_l2),
      .i_line_len   (line_len),
      .i_flag_idx   (flag_idx),
      .o_ADC_frame  (frame),
      .o_adc_start  (adc_start),
      .o_pixel_flag (pixel_flag),
      .o_line_done  (line_done),
      .o_pix_idx    (pix_idx),
      .o_overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log stamped with the cycle number in which each output pulse is visible.
   always @(negedge clk) begin
      if (rst_n) begin
         if (adc_start) strobe_q.push_back(cyc);
         if (pixel_flag) begin
            flag_q.push_back(cyc);
            flag_pix_q.push_back(int'(pix_idx));
         end
         if (line_done) begin
            done_q.push_back(cyc);
            done_pix_q.push_back(int'(pix_idx));
         end
         if (frame && !frame_prev) frame_rises++;
         frame_prev = frame;
      end else begin
         frame_prev = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_p(output int cp);
      @(negedge clk);
      phi_p = 1'b1;
      cp    = cyc;
      wait_cycles(3);
      phi_p = 1'b0;
   endtask

   task automatic pulse_l2(input int period, output int c);
      int hi;
      hi = (period / 2 < 1) ? 1 : period / 2;
      @(negedge clk);
      phi_l2 = 1'b1;
      c      = cyc;
      wait_cycles(hi);
      phi_l2 = 1'b0;
      wait_cycles(period - hi - 1);
   endtask

   // Model: an input edge driven in cycle c becomes a rise in c+3; registered results show in c+4,
   // and the strobe for a counted pixel shows ADC_DLY cycles after the rise.
   task automatic apply_stimulus(input int len, input int flag, input int n, input int period,
                                 output int got_strobes, output int got_flags, output int got_dones,
                                 output int got_pix, output int got_frame);
      int sb, fb, db, rb, cp, c, counted, exp_flags, exp_dones, exp_rises, act;
      int r[$];
      sb = strobe_q.size();
      fb = flag_q.size();
      db = done_q.size();
      rb = frame_rises;
      line_len = PIX_W'(len);
      flag_idx = PIX_W'(flag);
      pulse_p(cp);
      check_output("frame_before_start", int'(frame), int'(prev_active));
      wait_cycles(1);
      check_output("frame_after_start", int'(frame), (len != 0) ? 1 : 0);
      check_output("pix_after_start", int'(pix_idx), 0);
      wait_cycles(1);
      for (int k = 0; k < n; k++) begin
         pulse_l2(period, c);
         r.push_back(c);
      end
      wait_cycles(ADC_DLY + 8);

      counted   = (len == 0) ? 0 : ((n < len) ? n : len);
      exp_flags = (flag >= 1 && flag <= counted) ? 1 : 0;
      exp_dones = (len == 0 || n >= len) ? 1 : 0;
      exp_rises = (len != 0 && !prev_active) ? 1 : 0;
      act       = (len != 0 && n < len) ? 1 : 0;

      got_strobes = strobe_q.size() - sb;
      got_flags   = flag_q.size() - fb;
      got_dones   = done_q.size() - db;
      got_pix     = int'(pix_idx);
      got_frame   = int'(frame);

      check_output("strobe_count", got_strobes, counted);
      if (got_strobes == counted)
         for (int k = 0; k < counted; k++)
            check_output($sformatf("strobe_time_px%0d", k + 1), strobe_q[sb + k], r[k] + 3 + ADC_DLY);
      check_output("flag_count", got_flags, exp_flags);
      if (got_flags == 1 && exp_flags == 1) begin
         check_output("flag_time", flag_q[fb], r[flag - 1] + 4);
         check_output("flag_pix", flag_pix_q[fb], flag);
      end
      check_output("done_count", got_dones, exp_dones);
      if (got_dones == 1 && exp_dones == 1) begin
         check_output("done_time", done_q[db], (len == 0) ? cp + 4 : r[len - 1] + 4);
         check_output("done_pix", done_pix_q[db], len);
      end
      check_output("frame_rises", frame_rises - rb, exp_rises);
      check_output("pix_end", got_pix, counted);
      check_output("frame_end", got_frame, act);
      check_output("overrun_normal", int'(overrun), 0);
      prev_active = (act != 0);
   endtask

   initial begin
      int gs, gf, gd, gp, gfr, cp, c, sb, db;

      vecs[0] = '{8, 5, 8, 10, 8, 1, 1, 8, 0};
      vecs[1] = '{8, 5, 10, 10, 8, 1, 1, 8, 0};
      vecs[2] = '{6, 0, 6, 5, 6, 0, 1, 6, 0};
      vecs[3] = '{4, 9, 4, 6, 4, 0, 1, 4, 0};
      vecs[4] = '{0, 1, 3, 6, 0, 0, 1, 0, 0};
      vecs[5] = '{10, 10, 5, 7, 5, 0, 0, 5, 1};
      vecs[6] = '{1, 1, 1, 5, 1, 1, 1, 1, 0};

      rst_n    = 1'b0;
      enable   = 1'b1;
      phi_p    = 1'b0;
      phi_l2   = 1'b0;
      line_len = '0;
      flag_idx = '0;
      wait_cycles(3);
      check_output("rst_frame", int'(frame), 0);
      check_output("rst_adc_start", int'(adc_start), 0);
      check_output("rst_pixel_flag", int'(pixel_flag), 0);
      check_output("rst_line_done", int'(line_done), 0);
      check_output("rst_pix_idx", int'(pix_idx), 0);
      check_output("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      wait_cycles(2);

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i].len, vecs[i].flag, vecs[i].npulses, vecs[i].period, gs, gf, gd, gp, gfr);
         check_output($sformatf("vec%0d_strobes", i), gs, vecs[i].exp_strobes);
         check_output($sformatf("vec%0d_flags", i), gf, vecs[i].exp_flags);
         check_output($sformatf("vec%0d_dones", i), gd, vecs[i].exp_dones);
         check_output($sformatf("vec%0d_pix", i), gp, vecs[i].exp_pix);
         check_output($sformatf("vec%0d_frame", i), gfr, vecs[i].exp_frame);
      end

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(int'($urandom_range(12, 1)), int'($urandom_range(14, 0)),
                        int'($urandom_range(14, 0)), int'($urandom_range(ADC_DLY + 6, ADC_DLY + 1)),
                        gs, gf, gd, gp, gfr);
      end

      // Line start and pixel edge in the same cycle at pixel 3: the line restarts and the pixel is dropped.
      line_len = 12'd8;
      flag_idx = 12'd5;
      pulse_p(cp);
      wait_cycles(2);
      for (int k = 0; k < 3; k++) pulse_l2(10, c);
      wait_cycles(3);
      check_output("pix_before_restart", int'(pix_idx), 3);
      sb = strobe_q.size();
      db = done_q.size();
      @(negedge clk);
      phi_p  = 1'b1;
      phi_l2 = 1'b1;
      wait_cycles(3);
      phi_p  = 1'b0;
      phi_l2 = 1'b0;
      wait_cycles(12);
      check_output("restart_pix", int'(pix_idx), 0);
      check_output("restart_strobes", strobe_q.size() - sb, 0);
      check_output("restart_dones", done_q.size() - db, 0);
      check_output("restart_frame", int'(frame), 1);
      prev_active = 1'b1;

      // Enable dropped while a strobe is pending: the strobe is cancelled and the count holds.
      line_len = 12'd10;
      flag_idx = 12'd0;
      pulse_p(cp);
      wait_cycles(2);
      for (int k = 0; k < 2; k++) pulse_l2(8, c);
      wait_cycles(2);
      sb = strobe_q.size();
      @(negedge clk);
      phi_l2 = 1'b1;
      wait_cycles(1);
      phi_l2 = 1'b0;
      wait_cycles(3);
      enable = 1'b0;
      wait_cycles(10);
      check_output("disable_frame", int'(frame), 0);
      check_output("disable_pix", int'(pix_idx), 3);
      check_output("disable_cancelled_strobe", strobe_q.size() - sb, 0);
      for (int k = 0; k < 2; k++) pulse_l2(8, c);
      wait_cycles(10);
      check_output("disable_pix_hold", int'(pix_idx), 3);
      check_output("disable_no_strobes", strobe_q.size() - sb, 0);
      enable = 1'b1;
      prev_active = 1'b0;

      // Pixel edges every 3 cycles against a 4-cycle delay: only the final strobe survives.
      line_len = 12'd30;
      pulse_p(cp);
      wait_cycles(2);
      sb = strobe_q.size();
      for (int k = 0; k < 6; k++) pulse_l2(3, c);
      wait_cycles(12);
      check_output("fast_pix", int'(pix_idx), 6);
      check_output("fast_strobes", strobe_q.size() - sb, 1);
`ifdef CCD_SEQ_OVERRUN_DET_EN
      check_output("overrun_set", int'(overrun), 1);
`else
      check_output("overrun_tied", int'(overrun), 0);
`endif
      pulse_p(cp);
      wait_cycles(2);
      check_output("overrun_after_line_start", int'(overrun), 0);
      prev_active = 1'b1;

      // Asynchronous reset in the middle of a line.
      line_len = 12'd20;
      flag_idx = 12'd0;
      pulse_p(cp);
      wait_cycles(2);
      for (int k = 0; k < 5; k++) pulse_l2(6, c);
      wait_cycles(4);
      check_output("pix_before_reset", int'(pix_idx), 5);
      #3 rst_n = 1'b0;
      #1;
      check_output("midrst_frame", int'(frame), 0);
      check_output("midrst_adc_start", int'(adc_start), 0);
      check_output("midrst_pixel_flag", int'(pixel_flag), 0);
      check_output("midrst_line_done", int'(line_done), 0);
      check_output("midrst_pix_idx", int'(pix_idx), 0);
      check_output("midrst_overrun", int'(overrun), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(2);
      prev_active = 1'b0;
      apply_stimulus(3, 2, 3, 6, gs, gf, gd, gp, gfr);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
